// File: rtl/prbs_qpsk_source.sv
// Dual-rail PRBS9 (x^9+x^5+1) bit source for a QPSK mapper, paced by an internal symbol divider
// with a registered valid/ready output. Optional I-rail error injection via PRBS_ERR_INJECT_EN.
module prbs_qpsk_source #(
   parameter logic [8:0]  SEED_I    = 9'h1FF,
   parameter logic [8:0]  SEED_Q    = 9'h0F5,
   parameter int unsigned OS_FACTOR = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_enable,
   input  logic        i_ready,
`ifdef PRBS_ERR_INJECT_EN
   input  logic        i_err_inj,
`endif
   output logic        o_bit_I,
   output logic        o_bit_Q,
   output logic        o_valid,
   output logic        o_overrun,
   output logic [15:0] o_sym_cnt
);

   // An all-zero LFSR would lock up, so a zero seed falls back to all-ones.
   localparam logic [8:0] SeedI  = (SEED_I == 9'd0) ? 9'h1FF : SEED_I;
   localparam logic [8:0] SeedQ  = (SEED_Q == 9'd0) ? 9'h1FF : SEED_Q;
   localparam logic [7:0] DivMax = 8'(OS_FACTOR - 1);

   logic [8:0]  lfsr_i_q, lfsr_i_d;
   logic [8:0]  lfsr_q_q, lfsr_q_d;
   logic [7:0]  div_q, div_d;
   logic        bit_i_q, bit_i_d;
   logic        bit_q_q, bit_q_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic [15:0] sym_cnt_q, sym_cnt_d;

   logic tick, accept, slot_free, load;

`ifdef PRBS_ERR_INJECT_EN
   logic err_inj_q;
   logic armed_q, armed_d;
   logic inject;
`endif

   always_comb begin
      tick      = i_enable && (div_q == DivMax);
      accept    = valid_q && i_ready;
      slot_free = !valid_q || accept;
      load      = tick && slot_free;

      lfsr_i_d  = lfsr_i_q;
      lfsr_q_d  = lfsr_q_q;
      div_d     = div_q;
      bit_i_d   = bit_i_q;
      bit_q_d   = bit_q_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      sym_cnt_d = sym_cnt_q;

      if (i_enable) begin
         div_d = (div_q == DivMax) ? 8'd0 : div_q + 8'd1;
      end

      if (load) begin
`ifdef PRBS_ERR_INJECT_EN
         bit_i_d = lfsr_i_q[8] ^ inject;
`else
         bit_i_d = lfsr_i_q[8];
`endif
         bit_q_d  = lfsr_q_q[8];
         lfsr_i_d = {lfsr_i_q[7:0], lfsr_i_q[8] ^ lfsr_i_q[4]};
         lfsr_q_d = {lfsr_q_q[7:0], lfsr_q_q[8] ^ lfsr_q_q[4]};
         valid_d  = 1'b1;
      end else if (accept) begin
         valid_d = 1'b0;
      end

      if (tick && !slot_free) begin
         overrun_d = 1'b1;
      end

      if (accept) begin
         sym_cnt_d = sym_cnt_q + 16'd1;
      end
   end

`ifdef PRBS_ERR_INJECT_EN
   // A rising edge coinciding with a load already applies to that load.
   always_comb begin
      inject  = armed_q || (i_err_inj && !err_inj_q);
      armed_d = load ? 1'b0 : inject;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_inj_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         err_inj_q <= i_err_inj;
         armed_q   <= armed_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_i_q  <= SeedI;
         lfsr_q_q  <= SeedQ;
         div_q     <= 8'd0;
         bit_i_q   <= 1'b0;
         bit_q_q   <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         sym_cnt_q <= 16'd0;
      end else begin
         lfsr_i_q  <= lfsr_i_d;
         lfsr_q_q  <= lfsr_q_d;
         div_q     <= div_d;
         bit_i_q   <= bit_i_d;
         bit_q_q   <= bit_q_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         sym_cnt_q <= sym_cnt_d;
      end
   end

   assign o_bit_I   = bit_i_q;
   assign o_bit_Q   = bit_q_q;
   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;
   assign o_sym_cnt = sym_cnt_q;

endmodule

// File: tb/tb_prbs_qpsk_source.sv
// Bench for prbs_qpsk_source: an OS_FACTOR=4 instance for pacing/stall/reset and an OS_FACTOR=1
// instance (zero Q seed) for the period check; accepted symbols are checked against a queue.
module tb_prbs_qpsk_source;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en4, rdy4, en1, rdy1;
   logic        bi4, bq4, v4, ov4;
   logic        bi1, bq1, v1, ov1;
   logic [15:0] cnt4, cnt1;
`ifdef PRBS_ERR_INJECT_EN
   logic        inj4 = 1'b0;
   logic        inj1 = 1'b0;
`endif

   prbs_qpsk_source #(.SEED_I(9'h1FF), .SEED_Q(9'h0F5), .OS_FACTOR(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (en4),
      .i_ready   (rdy4),
`ifdef PRBS_ERR_INJECT_EN
      .i_err_inj (inj4),
`endif
      .o_bit_I   (bi4),
      .o_bit_Q   (bq4),
      .o_valid   (v4),
      .o_overrun (ov4),
      .o_sym_cnt (cnt4)
   );

   prbs_qpsk_source #(.SEED_I(9'h1FF), .SEED_Q(9'h000), .OS_FACTOR(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (en1),
      .i_ready   (rdy1),
`ifdef PRBS_ERR_INJECT_EN
      .i_err_inj (inj1),
`endif
      .o_bit_I   (bi1),
      .o_bit_Q   (bq1),
      .o_valid   (v1),
      .o_overrun (ov1),
      .o_sym_cnt (cnt1)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  sb4[$];
   logic [1:0]  sb1[$];
   logic [15:0] mcnt4, mcnt1;
   int          acc1;
   logic        cap_i[0:1021];
   logic        cap_q[0:1021];

   function automatic logic [8:0] adv(input logic [8:0] x);
      return {x[7:0], x[8] ^ x[4]};
   endfunction

   task automatic fill4();
      logic [8:0] a = 9'h1FF;
      logic [8:0] b = 9'h0F5;
      sb4.delete();
      for (int k = 0; k < 600; k++) begin
         sb4.push_back({a[8], b[8]});
         a = adv(a);
         b = adv(b);
      end
   endtask

   task automatic fill1();
      logic [8:0] a = 9'h1FF;
      logic [8:0] b = 9'h1FF;
      sb1.delete();
      for (int k = 0; k < 1100; k++) begin
         sb1.push_back({a[8], b[8]});
         a = adv(a);
         b = adv(b);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks any symbol accepted at the coming edge, then advances one clock.
   task automatic cycle();
      logic [1:0] e;
      if (!rst && v4 && rdy4) begin
         e = (sb4.size() != 0) ? sb4.pop_front() : 2'bxx;
         chk("sym4", {30'd0, bi4, bq4}, {30'd0, e});
         chk("cnt4", {16'd0, cnt4}, {16'd0, mcnt4});
         mcnt4++;
      end
      if (!rst && v1 && rdy1) begin
         e = (sb1.size() != 0) ? sb1.pop_front() : 2'bxx;
         chk("sym1", {30'd0, bi1, bq1}, {30'd0, e});
         chk("cnt1", {16'd0, cnt1}, {16'd0, mcnt1});
         mcnt1++;
         if (acc1 < 1022) begin
            cap_i[acc1] = bi1;
            cap_q[acc1] = bq1;
         end
         acc1++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] hold;
      int bad, ones_i, ones_q;

      rst = 1'b1; en4 = 1'b0; rdy4 = 1'b0; en1 = 1'b0; rdy1 = 1'b0;
      mcnt4 = '0; mcnt1 = '0; acc1 = 0;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      chk("rst_valid4", {31'd0, v4}, 0);
      chk("rst_cnt4", {16'd0, cnt4}, 0);
      chk("rst_ovr4", {31'd0, ov4}, 0);
      chk("rst_bits4", {30'd0, bi4, bq4}, 0);
      chk("rst_valid1", {31'd0, v1}, 0);
      chk("rst_cnt1", {16'd0, cnt1}, 0);
      fill4();
      fill1();

      // Pacing: first valid on the 4th edge after enable, then every 4 cycles.
      en4 = 1'b1; rdy4 = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         cycle();
         chk("valid_pace", {31'd0, v4}, {31'd0, (n % 4) == 0});
         if (n == 4) chk("first_bitI", {31'd0, bi4}, 1);
      end

      // Back-pressure, with enable dropped for the last few cycles.
      rdy4 = 1'b0;
      hold = {bi4, bq4};
      for (int n = 1; n <= 48; n++) begin
         if (n == 41) en4 = 1'b0;
         cycle();
         chk("hold_valid", {31'd0, v4}, 1);
         chk("hold_bits", {30'd0, bi4, bq4}, {30'd0, hold});
      end
      chk("overrun_set", {31'd0, ov4}, 1);
      en4 = 1'b1; rdy4 = 1'b1;

      for (int g = 0; g < 600 && mcnt4 < 16'd100; g++) cycle();
      chk("reach100", {16'd0, mcnt4}, 100);

      // Mid-run reset restarts both rails from their seeds.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mrst_ovr", {31'd0, ov4}, 0);
      chk("mrst_cnt", {16'd0, cnt4}, 0);
      chk("mrst_valid", {31'd0, v4}, 0);
      fill4();
      mcnt4 = '0;
      for (int n = 0; n < 40; n++) cycle();
      chk("mrst_accepts", {16'd0, cnt4}, {16'd0, mcnt4});

`ifdef PRBS_ERR_INJECT_EN
      for (int g = 0; g < 8 && v4; g++) cycle();
      chk("inj_idle", {31'd0, v4}, 0);
      sb4[0][1] = ~sb4[0][1];
      inj4 = 1'b1;
      cycle();
      inj4 = 1'b0;
      for (int n = 0; n < 40; n++) cycle();
`endif

      // Full-rate period check.
      en4 = 1'b0;
      en1 = 1'b1; rdy1 = 1'b1;
      for (int g = 0; g < 1100 && acc1 < 1022; g++) cycle();
      en1 = 1'b0; rdy1 = 1'b0;
      chk("acc1", acc1, 1022);
      chk("cnt1_final", {16'd0, cnt1}, 1022);
      bad = 0; ones_i = 0; ones_q = 0;
      for (int k = 0; k < 511; k++) begin
         if (cap_i[k] !== cap_i[k + 511] || cap_q[k] !== cap_q[k + 511]) bad++;
         if (cap_i[k] === 1'b1) ones_i++;
         if (cap_q[k] === 1'b1) ones_q++;
      end
      chk("period511", bad, 0);
      chk("ones_i", ones_i, 256);
      chk("ones_q", ones_q, 256);
      chk("ovr1_clear", {31'd0, ov1}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
